// File: rtl/data_table_task_sched.sv
// Task scheduler for the data table: buffers tasks in a FWFT FIFO and dispatches them
// in order to the opcode-selected engine, draining all engines between opcode classes.
module data_table_task_sched #(
    parameter int TASK_W     = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int BUSY_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [TASK_W-1:0]             task_i,
    input  logic [1:0]                    task_opcode_i,
    input  logic                          task_valid_i,
    output logic                          task_ready_o,
    output logic [TASK_W-1:0]             eng_task_o,
    output logic [3:0]                    eng_valid_o,
    input  logic [3:0]                    eng_ready_i,
    input  logic [3:0]                    eng_busy_i,
    output logic                          draining_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used_o,
    output logic [CNT_W-1:0]              switch_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = TASK_W + 2;
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [2:0]     LAT_L   = 3'(BUSY_LAT);
    localparam logic [1:0]     OP_INIT = 2'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    used_q, used_d;
    state_e            state_q, state_d;
    logic              cur_vld_q, cur_vld_d;
    logic [1:0]        cur_op_q, cur_op_d;
    logic              force_drain_q, force_drain_d;
    logic [2:0]        drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  switch_cnt_q, switch_cnt_d;

    logic [1:0]        head_op;
    logic              empty;
    logic              push;
    logic              pop;
    logic              dispatch_ok;

    assign head_op      = mem_q[rd_ptr_q][ENT_W-1 -: 2];
    assign eng_task_o   = mem_q[rd_ptr_q][TASK_W-1:0];
    assign empty        = (used_q == '0);
    assign task_ready_o = (used_q < DEPTH_L);
    assign push         = task_valid_i && task_ready_o;
    assign dispatch_ok  = (state_q == ST_RUN) && !empty && !force_drain_q &&
                          (!cur_vld_q || (head_op == cur_op_q));
    assign eng_valid_o  = dispatch_ok ? (4'b0001 << head_op) : '0;
    assign pop          = dispatch_ok && eng_ready_i[head_op];

    assign draining_o   = (state_q == ST_DRAIN);
    assign fifo_used_o  = used_q;
    assign switch_cnt_o = switch_cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        if (push) begin
            mem_d[wr_ptr_q] = {task_opcode_i, task_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   used_d = used_q + (PTR_W+1)'(1);
            2'b01:   used_d = used_q - (PTR_W+1)'(1);
            default: used_d = used_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cur_vld_d     = cur_vld_q;
        cur_op_d      = cur_op_q;
        force_drain_d = force_drain_q;
        drain_cnt_d   = drain_cnt_q;
        switch_cnt_d  = switch_cnt_q;

        if (drain_cnt_q != '0) begin
            drain_cnt_d = drain_cnt_q - 3'd1;
        end

        case (state_q)
            ST_RUN: begin
                // Pop and the drain entry are mutually exclusive via dispatch_ok.
                if (pop) begin
                    cur_op_d    = head_op;
                    cur_vld_d   = 1'b1;
                    drain_cnt_d = LAT_L;
                    if (head_op == OP_INIT) begin
                        force_drain_d = 1'b1;
                    end
                end else if (!empty && ((cur_vld_q && (head_op != cur_op_q)) || force_drain_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((drain_cnt_q == '0) && (eng_busy_i == '0)) begin
                    state_d       = ST_RUN;
                    cur_op_d      = head_op;
                    force_drain_d = 1'b0;
                    switch_cnt_d  = switch_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            used_q        <= '0;
            state_q       <= ST_RUN;
            cur_vld_q     <= 1'b0;
            cur_op_q      <= '0;
            force_drain_q <= 1'b0;
            drain_cnt_q   <= '0;
            switch_cnt_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            used_q        <= used_d;
            state_q       <= state_d;
            cur_vld_q     <= cur_vld_d;
            cur_op_q      <= cur_op_d;
            force_drain_q <= force_drain_d;
            drain_cnt_q   <= drain_cnt_d;
            switch_cnt_q  <= switch_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_data_table_task_sched.sv
// Directed bench for data_table_task_sched (FIFO_DEPTH=8, BUSY_LAT=3).
module tb_data_table_task_sched;

    localparam int TASK_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [TASK_W-1:0] task_data;
    logic [1:0]        task_op;
    logic              task_valid;
    logic              task_ready;
    logic [TASK_W-1:0] eng_task;
    logic [3:0]        eng_valid;
    logic [3:0]        eng_ready;
    logic [3:0]        eng_busy;
    logic              draining;
    logic [3:0]        fifo_used;
    logic [15:0]       switch_cnt;

    int vectors     = 0;
    int miscompares = 0;

    data_table_task_sched #(
        .TASK_W    (TASK_W),
        .FIFO_DEPTH(8),
        .BUSY_LAT  (3),
        .CNT_W     (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .task_i       (task_data),
        .task_opcode_i(task_op),
        .task_valid_i (task_valid),
        .task_ready_o (task_ready),
        .eng_task_o   (eng_task),
        .eng_valid_o  (eng_valid),
        .eng_ready_i  (eng_ready),
        .eng_busy_i   (eng_busy),
        .draining_o   (draining),
        .fifo_used_o  (fifo_used),
        .switch_cnt_o (switch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change 1 time unit after the edge, outputs are sampled 1 later.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [63:0] d,
                       input logic [3:0] rdy, input logic [3:0] bsy);
        @(posedge clk);
        #1;
        task_valid = v;
        task_op    = op;
        task_data  = d;
        eng_ready  = rdy;
        eng_busy   = bsy;
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [3:0]  f_busy [16];
        logic [3:0]  f_vld  [16];
        logic        f_drn  [16];
        logic        f_in_v [16];
        logic [1:0]  f_in_op[16];

        rst = 1'b1; task_data = '0; task_op = '0; task_valid = 1'b0;
        eng_ready = '0; eng_busy = '0;
        @(posedge clk);
        @(posedge clk);
        #1; rst = 1'b0; #1;
        chk("rst_used", 64'(fifo_used), 64'd0);
        chk("rst_valid", 64'(eng_valid), 64'd0);
        chk("rst_drain", 64'(draining), 64'd0);
        chk("rst_switch", 64'(switch_cnt), 64'd0);
        chk("rst_ready", 64'(task_ready), 64'd1);

        // SEARCH stream, 1 per cycle
        cyc(1'b1, 2'd1, 64'hA000_0000_0000_0001, 4'b0010, 4'b0000);
        chk("s_first_latency", 64'(eng_valid), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) cyc(1'b1, 2'd1, 64'hA000_0000_0000_0001 + 64'(k), 4'b0010, 4'b0000);
            else       cyc(1'b0, 2'd1, 64'd0, 4'b0010, 4'b0000);
            chk("s_valid", 64'(eng_valid), 64'b0010);
            chk("s_payload", eng_task, 64'hA000_0000_0000_0000 + 64'(k));
            chk("s_used", 64'(fifo_used), 64'd1);
        end
        cyc(1'b0, 2'd1, 64'd0, 4'b0010, 4'b0000);
        chk("s_empty_valid", 64'(eng_valid), 64'd0);
        chk("s_switch", 64'(switch_cnt), 64'd0);

        // FIFO full
        for (int j = 0; j <= 8; j++) begin
            cyc(1'b1, 2'd1, 64'hB000_0000_0000_0000 + 64'(j), 4'b0000, 4'b0000);
            chk("full_ready", 64'(task_ready), (j < 8) ? 64'd1 : 64'd0);
        end
        chk("full_used", 64'(fifo_used), 64'd8);
        chk("full_hold_valid", 64'(eng_valid), 64'b0010);
        chk("full_hold_payload", eng_task, 64'hB000_0000_0000_0000);
        cyc(1'b0, 2'd1, 64'd0, 4'b0010, 4'b0000);
        chk("full_pop_ready", 64'(task_ready), 64'd0);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 2'd1, 64'd0, 4'b0010, 4'b0000);
            if (k == 1) begin
                chk("after_pop_ready", 64'(task_ready), 64'd1);
                chk("after_pop_used", 64'(fifo_used), 64'd7);
            end
            chk("full_order", eng_task, 64'hB000_0000_0000_0000 + 64'(k));
            chk("full_order_valid", 64'(eng_valid), 64'b0010);
        end
        cyc(1'b0, 2'd1, 64'd0, 4'b0010, 4'b0000);
        chk("full_drained_used", 64'(fifo_used), 64'd0);
        chk("full_drained_valid", 64'(eng_valid), 64'd0);

        // SEARCH -> INSERT with busy[1] high for 5 cycles after the pop
        cyc(1'b1, 2'd1, 64'hC0, 4'b0110, 4'b0000);
        chk("sw_empty", 64'(eng_valid), 64'd0);
        cyc(1'b1, 2'd2, 64'hC1, 4'b0110, 4'b0000);
        chk("sw_search_valid", 64'(eng_valid), 64'b0010);
        chk("sw_search_payload", eng_task, 64'hC0);
        cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0010);
        chk("sw_enter_valid", 64'(eng_valid), 64'd0);
        chk("sw_enter_drain", 64'(draining), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0010);
            chk("sw_draining", 64'(draining), 64'd1);
            chk("sw_hold_valid", 64'(eng_valid), 64'd0);
        end
        cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
        chk("sw_exit_drain", 64'(draining), 64'd1);
        chk("sw_exit_valid", 64'(eng_valid), 64'd0);
        cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
        chk("sw_insert_valid", 64'(eng_valid), 64'b0100);
        chk("sw_insert_payload", eng_task, 64'hC1);
        chk("sw_run", 64'(draining), 64'd0);
        chk("sw_count", 64'(switch_cnt), 64'd1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
        chk("sw_idle_valid", 64'(eng_valid), 64'd0);

        // INSERT -> SEARCH with no busy: drain length set by BUSY_LAT alone
        cyc(1'b1, 2'd2, 64'hD0, 4'b0110, 4'b0000);
        cyc(1'b1, 2'd1, 64'hD1, 4'b0110, 4'b0000);
        chk("lat_insert_valid", 64'(eng_valid), 64'b0100);
        chk("lat_insert_payload", eng_task, 64'hD0);
        cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
        chk("lat_enter_valid", 64'(eng_valid), 64'd0);
        chk("lat_enter_drain", 64'(draining), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
            chk("lat_draining", 64'(draining), 64'd1);
            chk("lat_hold_valid", 64'(eng_valid), 64'd0);
        end
        cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);
        chk("lat_search_valid", 64'(eng_valid), 64'b0010);
        chk("lat_search_payload", eng_task, 64'hD1);
        chk("lat_count", 64'(switch_cnt), 64'd2);
        for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, 64'd0, 4'b0110, 4'b0000);

        // INIT, INIT, SEARCH with busy[0] pulses after each INIT pop
        f_in_v  = '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
        f_in_op = '{2'd0,2'd0,2'd1,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};
        f_busy  = '{4'h0,4'h0,4'h0,4'h0,4'h1,4'h1,4'h1,4'h1,4'h0,4'h0,4'h1,4'h1,4'h1,4'h1,4'h0,4'h0};
        f_vld   = '{4'h0,4'h0,4'h0,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h2};
        f_drn   = '{0,0,1,0,0,1,1,1,1,0,0,1,1,1,1,0};
        for (int k = 0; k < 16; k++) begin
            cyc(f_in_v[k], f_in_op[k], 64'hE0 + 64'(k), 4'b0011, f_busy[k]);
            chk("init_valid", 64'(eng_valid), 64'(f_vld[k]));
            chk("init_drain", 64'(draining), 64'(f_drn[k]));
            chk("init_overlap", 64'((eng_valid != '0) && ((eng_busy & ~eng_valid) != '0)), 64'd0);
            if (k == 3)  begin chk("init0_payload", eng_task, 64'hE0); chk("init0_count", 64'(switch_cnt), 64'd3); end
            if (k == 9)  begin chk("init1_payload", eng_task, 64'hE1); chk("init1_count", 64'(switch_cnt), 64'd4); end
            if (k == 15) begin chk("srch_payload", eng_task, 64'hE2); chk("srch_count", 64'(switch_cnt), 64'd5); end
        end

        // Reset while DRAIN with 5 tasks queued
        for (int k = 0; k < 5; k++) cyc(1'b1, 2'd2, 64'hF0 + 64'(k), 4'b0000, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b1; task_valid = 1'b0; #1;
        chk("pre_rst_drain", 64'(draining), 64'd1);
        chk("pre_rst_used", 64'(fifo_used), 64'd5);
        chk("pre_rst_valid", 64'(eng_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; eng_busy = '0; #1;
        chk("mid_rst_used", 64'(fifo_used), 64'd0);
        chk("mid_rst_valid", 64'(eng_valid), 64'd0);
        chk("mid_rst_drain", 64'(draining), 64'd0);
        chk("mid_rst_switch", 64'(switch_cnt), 64'd0);
        chk("mid_rst_ready", 64'(task_ready), 64'd1);
        cyc(1'b1, 2'd3, 64'h1234, 4'b1000, 4'b0000);
        chk("post_rst_empty", 64'(eng_valid), 64'd0);
        cyc(1'b0, 2'd0, 64'd0, 4'b1000, 4'b0000);
        chk("post_rst_valid", 64'(eng_valid), 64'b1000);
        chk("post_rst_payload", eng_task, 64'h1234);
        chk("post_rst_drain", 64'(draining), 64'd0);
        cyc(1'b0, 2'd0, 64'd0, 4'b1000, 4'b0000);
        chk("post_rst_used", 64'(fifo_used), 64'd0);
        chk("post_rst_idle", 64'(eng_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
